// File: rtl/proc_ctrl.sv
// Control sequencer for the 8-bit processor: fetches an opcode into IR and steps R0-R7/A/G load enables, bus selects and add/sub.
// Latency: mv/mvi finish (done) in the cycle after fetch (T1); add/sub finish three cycles after fetch (T3).
// Backpressure: none; run is only sampled in T0, and busy flags that a new request would be ignored.
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   run, din    - start request and instruction word (T0) / immediate operand (T1 of mvi)
//   done, busy  - last-cycle pulse of each instruction; high while not in T0
//   ir_load     - IR capture strobe
//   rin/ain/gin - load enables for R0-R7 (one-hot), A and G; addsub selects subtract into G
//   sel_reg/sel_g/sel_din - one-hot bus source select
//   instr_cnt   - wrapping count of completed instructions
module proc_ctrl #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [DW-1:0] din,
    output logic          done,
    output logic          busy,
    output logic          ir_load,
    output logic [7:0]    rin,
    output logic          ain,
    output logic          gin,
    output logic          addsub,
    output logic [7:0]    sel_reg,
    output logic          sel_g,
    output logic          sel_din,
    output logic [7:0]    instr_cnt
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;

    state_t     state;
    logic [7:0] ir;
    logic [1:0] op;
    logic [2:0] rx;
    logic [2:0] ry;

    assign op = ir[7:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= T0;
            ir        <= 8'h00;
            instr_cnt <= 8'h00;
        end else begin
            case (state)
                T0: begin
                    if (run) begin
                        ir    <= din[7:0];
                        state <= T1;
                    end
                end
                // op[1] distinguishes the two-step moves from the ALU ops
                T1: state <= op[1] ? T2 : T0;
                T2: state <= T3;
                T3: state <= T0;
            endcase
            if (done) begin
                instr_cnt <= instr_cnt + 8'd1;
            end
        end
    end

    // Reset gating keeps the strobe low while rst_n is held, even if run is high.
    assign ir_load = rst_n && (state == T0) && run;
    assign busy    = (state != T0);

    always_comb begin
        done    = 1'b0;
        rin     = 8'h00;
        ain     = 1'b0;
        gin     = 1'b0;
        addsub  = 1'b0;
        sel_reg = 8'h00;
        sel_g   = 1'b0;
        sel_din = 1'b0;
        case (state)
            T0: ;
            T1: begin
                if (op == OP_MV) begin
                    sel_reg = 8'h01 << ry;
                    rin     = 8'h01 << rx;
                    done    = 1'b1;
                end else if (op == OP_MVI) begin
                    sel_din = 1'b1;
                    rin     = 8'h01 << rx;
                    done    = 1'b1;
                end else begin
                    sel_reg = 8'h01 << rx;
                    ain     = 1'b1;
                end
            end
            T2: begin
                sel_reg = 8'h01 << ry;
                gin     = 1'b1;
                addsub  = ir[6];
            end
            T3: begin
                sel_g = 1'b1;
                rin   = 8'h01 << rx;
                done  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl: cycle-by-cycle vector table, plus a tiny datapath model
// (R0-R7, A, G, bus mux) driven by the control outputs to confirm register results,
// an async-reset-mid-instruction sequence, and a 256-instruction counter wrap run.
module tb_proc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] din;
    logic       done, busy, ir_load, ain, gin, addsub, sel_g, sel_din;
    logic [7:0] rin, sel_reg, instr_cnt;

    proc_ctrl #(.DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .din      (din),
        .done     (done),
        .busy     (busy),
        .ir_load  (ir_load),
        .rin      (rin),
        .ain      (ain),
        .gin      (gin),
        .addsub   (addsub),
        .sel_reg  (sel_reg),
        .sel_g    (sel_g),
        .sel_din  (sel_din),
        .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int inv_bad = 0;

    // ---- datapath model fed by the controller's outputs ----
    logic [7:0] regs [8];
    logic [7:0] a_reg, g_reg, bus;

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        a_reg = 8'h00;
        g_reg = 8'h00;
    end

    always_comb begin
        bus = 8'h00;
        if (sel_din) bus = din;
        else if (sel_g) bus = g_reg;
        else for (int i = 0; i < 8; i++) if (sel_reg[i]) bus = regs[i];
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 8; i++) if (rin[i]) regs[i] <= bus;
            if (ain) a_reg <= bus;
            if (gin) g_reg <= addsub ? (a_reg - bus) : (a_reg + bus);
        end
    end

    // ---- invariant monitor, sampled away from the active edge ----
    always @(negedge clk) begin
        if ((sel_reg & (sel_reg - 8'd1)) != 8'h00) inv_bad++;
        if ((rin & (rin - 8'd1)) != 8'h00) inv_bad++;
        if (int'(sel_reg != 8'h00) + int'(sel_g) + int'(sel_din) > 1) inv_bad++;
        if (addsub && !gin) inv_bad++;
    end

    // control word: {done,busy,ir_load,rin,ain,gin,addsub,sel_reg,sel_g,sel_din,instr_cnt}
    function automatic logic [31:0] ctl(input logic d, input logic b, input logic il,
                                        input logic [7:0] r, input logic a, input logic g,
                                        input logic s, input logic [7:0] sr, input logic sg,
                                        input logic sd, input logic [7:0] cnt);
        return {d, b, il, r, a, g, s, sr, sg, sd, cnt};
    endfunction

    function automatic logic [31:0] act();
        return {done, busy, ir_load, rin, ain, gin, addsub, sel_reg, sel_g, sel_din, instr_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    typedef struct {
        logic        run;
        logic [7:0]  din;
        logic [31:0] exp;
        logic        chk_r1;
        logic [7:0]  r1;
    } vec_t;

    vec_t vecs [18];
    int   ndone;
    logic [5:0] rnd;

    initial begin
        //                 run   din    ctl(d  b  il rin    a  g  s  sel_r  sg sd cnt)       chk r1
        vecs[0]  = '{1'b1, 8'h4D, ctl(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd0), 1'b0, 8'h00}; // fetch mvi R1
        vecs[1]  = '{1'b0, 8'h5A, ctl(1, 1, 0, 8'h02, 0, 0, 0, 8'h00, 0, 1, 8'd0), 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h50, ctl(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd1), 1'b1, 8'h5A}; // fetch mvi R2
        vecs[3]  = '{1'b0, 8'h03, ctl(1, 1, 0, 8'h04, 0, 0, 0, 8'h00, 0, 1, 8'd1), 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 8'h0A, ctl(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd2), 1'b0, 8'h00}; // fetch mv R1,R2
        vecs[5]  = '{1'b0, 8'h00, ctl(1, 1, 0, 8'h02, 0, 0, 0, 8'h04, 0, 0, 8'd2), 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 8'hFF, ctl(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd3), 1'b1, 8'h03}; // idle
        vecs[7]  = '{1'b1, 8'h8A, ctl(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd3), 1'b0, 8'h00}; // fetch add R1,R2
        vecs[8]  = '{1'b0, 8'h00, ctl(0, 1, 0, 8'h00, 1, 0, 0, 8'h02, 0, 0, 8'd3), 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, ctl(0, 1, 0, 8'h00, 0, 1, 0, 8'h04, 0, 0, 8'd3), 1'b0, 8'h00};
        vecs[10] = '{1'b0, 8'h00, ctl(1, 1, 0, 8'h02, 0, 0, 0, 8'h00, 1, 0, 8'd3), 1'b0, 8'h00};
        vecs[11] = '{1'b1, 8'hCA, ctl(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd4), 1'b1, 8'h06}; // fetch sub R1,R2
        vecs[12] = '{1'b1, 8'hCA, ctl(0, 1, 0, 8'h00, 1, 0, 0, 8'h02, 0, 0, 8'd4), 1'b0, 8'h00};
        vecs[13] = '{1'b1, 8'hCA, ctl(0, 1, 0, 8'h00, 0, 1, 1, 8'h04, 0, 0, 8'd4), 1'b0, 8'h00};
        vecs[14] = '{1'b1, 8'hCA, ctl(1, 1, 0, 8'h02, 0, 0, 0, 8'h00, 1, 0, 8'd4), 1'b0, 8'h00};
        vecs[15] = '{1'b1, 8'h1B, ctl(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd5), 1'b1, 8'h03}; // fetch mv R3,R3
        vecs[16] = '{1'b1, 8'h1B, ctl(1, 1, 0, 8'h08, 0, 0, 0, 8'h08, 0, 0, 8'd5), 1'b0, 8'h00};
        vecs[17] = '{1'b0, 8'h00, ctl(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'd6), 1'b1, 8'h03};

        // reset state: outputs low even with run requested
        rst_n = 1'b0;
        run   = 1'b1;
        din   = 8'h4D;
        #2;
        check("reset_outputs", act(), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run = vecs[i].run;
            din = vecs[i].din;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), act(), vecs[i].exp);
            if (vecs[i].chk_r1) check($sformatf("vec%0d_r1", i), {24'h0, regs[1]}, {24'h0, vecs[i].r1});
            @(posedge clk);
            #1;
        end
        check("r2_value", {24'h0, regs[2]}, 32'h03);

        // async reset in T2 of an add
        run = 1'b1;
        din = 8'h8A;
        @(posedge clk); #1;
        run = 1'b0;
        din = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("t2_before_reset", act(), ctl(0, 1, 0, 8'h00, 0, 1, 0, 8'h04, 0, 0, 8'd6));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", act(), 32'h0);
        check("async_reset_ir", {24'h0, dut.ir}, 32'h0);
        @(posedge clk); #1;
        check("held_reset_outputs", act(), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", act(), 32'h0);
        @(posedge clk); #1;

        // 256 back-to-back mv instructions with run held: counter must wrap
        ndone = 0;
        run = 1'b1;
        for (int i = 0; i < 512; i++) begin
            rnd = 6'($urandom_range(0, 63));
            din = {2'b00, rnd};
            @(negedge clk);
            if (done) ndone++;
            if (i == 255) check("cnt_midway", {24'h0, instr_cnt}, 32'h7F);
            @(posedge clk); #1;
        end
        run = 1'b0;
        check("done_pulses", ndone, 256);
        check("cnt_wrap", {24'h0, instr_cnt}, 32'h0);
        @(negedge clk);
        check("invariants", inv_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
